memory_stage: RTL and testbench
===============================

# memory_stage

Memory stage of the SEQ Y86-64 datapath. Sits directly downstream of `execute`. It consumes `valE` from execute, together with `valA`/`valP` carried alongside, and performs the data-memory read or write for the instruction. It returns `valM` and the final instruction status to writeback and PC-update. Accesses are serialized by a valid/ready handshake with a configurable fixed latency, and the block halts stickily on any non-AOK status.

## Interface
- `MEM_BYTES`, 1024: data memory size in bytes; multiple of 8, ≥ 16.
- `ACCESS_LAT`, 1: cycles from accept to response; ≥ 1.
- `clk` in 1: clock. All state updates on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request.
- `icode` in 4: Y86 instruction code.
- `instr_valid` in 1: fetch decoded a legal instruction.
- `imem_error` in 1: fetch address fault.
- `valE` in 64: ALU result from execute.
- `valA` in 64: register operand A.
- `valP` in 64: next sequential PC.
- `out_valid` out 1: one-cycle response strobe.
- `valM` out 64: read data, little-endian 8 bytes.
- `stat` out 3: AOK=1, HLT=2, ADR=3, INS=4.

## Operation
- **Address/data selection, captured at accept:**
  - rmmovq (4) and pushq (A): write `valA` to `valE`.
  - call (8): write `valP` to `valE`.
  - mrmovq (5): read from `valE`.
  - popq (B) and ret (9): read from `valA`.
  - All other icodes: no memory access; `valM`=0.
- **dmem_error:** access flagged when the unsigned address > `MEM_BYTES`-8. The comparison must not wrap for addresses near 2^64.
- **stat priority:** `imem_error`|dmem_error → ADR; else `!instr_valid` → INS; else icode==0 → HLT; else AOK.
- **No-op on error:** when stat ≠ AOK, no memory write occurs and `valM`=0.
- **FSM states:**
  - IDLE: `in_ready`=1. On `in_valid` → BUSY; load latency counter with `ACCESS_LAT`-1 and latch all inputs.
  - BUSY: counter decrements each cycle. At 0 the block performs the write/read, drives `out_valid`=1 with `valM`/`stat` for that cycle, then goes → IDLE if stat==AOK, else → HALTED.
  - HALTED: `in_ready`=0 and no accesses until reset. `stat` holds its last value; `out_valid`=0.
- **Reset:** memory contents are not cleared by reset.
- **Inputs outside IDLE:** ignored while not in IDLE.

## Timing
- **Reset values:** `out_valid`=0, `valM`=0, `stat`=1 (AOK), FSM=IDLE. `in_ready`=0 while `rst_n`=0.
- **Accept edge:** `in_valid`&&`in_ready` sampled at edge N.
- **Response:** `out_valid` is high during the cycle after edge N+`ACCESS_LAT`-1, i.e. visible `ACCESS_LAT` cycles after accept. The write commits on that same edge.
- **Next request:** the earliest next accept is the edge after the `out_valid` cycle. Throughput is one access per `ACCESS_LAT`+1 cycles.
- **Read-after-write:** back-to-back transactions to the same address see the new data, because accesses are serialized.
- **Reset in BUSY:** the pending write is discarded, no `out_valid` is produced, and the FSM returns to IDLE.
- **Reset in HALTED:** returns to IDLE.
- **`valM`:** holds its value between strobes and is cleared to 0 on reset.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:** any memory access with address[2:0] ≠ 0 raises dmem_error. Result is stat=ADR, no write, then HALTED.
- **`MEM_ALIGN_CHECK_EN` undefined:** unaligned accesses are legal byte-granular little-endian accesses.

## Structure
- **`y86_pkg`** holds:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - stat constants: SAOK, SHLT, SADR, SINS.
  - The FSM state enum.
- **`dmem_array`** sub-module: a `MEM_BYTES` byte array with one synchronous 8-byte little-endian write port and a combinational 8-byte read port. The FSM, address muxing and status logic stay in `memory_stage`.

## Test plan
1. rmmovq, `valE`=0x100, `valA`=0x1122334455667788; then mrmovq, `valE`=0x100 → second response `valM`=0x1122334455667788, stat=1. Each `out_valid` arrives `ACCESS_LAT` cycles after accept.
2. pushq, `valE`=0x1F8, `valA`=42; then popq, `valA`=0x1F8 → `valM`=42. Also call, `valE`=0x1F0, `valP`=0x40; then ret, `valA`=0x1F0 → `valM`=0x40.
3. mrmovq with `valE`=`MEM_BYTES`-4, and with `valE`=0xFFFFFFFFFFFFFFFC → stat=3, `valM`=0, then `in_ready` stays 0 for 10 cycles. A further `in_valid` gets no response.
4. icode=0 → stat=2, no write. Also `instr_valid`=0 with `imem_error`=1 → stat=3 (ADR over INS). Both cases halt.
5. `ACCESS_LAT`=3: rmmovq to 0x80; assert `rst_n`=0 one cycle after accept → no `out_valid`. A subsequent mrmovq from 0x80 returns the prior contents.
6. rmmovq to 0x103 → with `MEM_ALIGN_CHECK_EN`: stat=3, halted. Without it: stat=1, and a readback from 0x103 returns the written value.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, memory-stage FSM states.
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2
    } mem_state_e;

    // Address faults outrank illegal instructions, which outrank halt.
    function automatic logic [2:0] resolve_stat(input logic       adr_fault,
                                                input logic       instr_valid,
                                                input logic [3:0] icode);
        if (adr_fault)           return SADR;
        else if (!instr_valid)   return SINS;
        else if (icode == IHALT) return SHLT;
        else                     return SAOK;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data memory: one synchronous 8-byte LE write port, one combinational 8-byte LE read port.
// Latency: write commits on the clock edge; read is combinational (0 cycles).
// Backpressure: none; caller guarantees both addresses are <= MEM_BYTES-8.
module dmem_array #(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata
);

    logic [7:0] mem [MEM_BYTES];

    // Eight-byte little-endian write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                mem[waddr + AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // Eight-byte little-endian read, byte granular so unaligned reads work.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[8*i +: 8] = mem[raddr + AW'(i)];
        end
    end

endmodule

// File: rtl/memory_stage.sv
// SEQ Y86-64 memory stage: selects address/data, accesses dmem, returns valM and final stat; halts on non-AOK.
// Latency: out_valid strobes ACCESS_LAT cycles after accept; one access per ACCESS_LAT+1 cycles.
// Backpressure: in_ready only in IDLE; never again after a non-AOK result until reset. Option macro: MEM_ALIGN_CHECK_EN.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES  = 1024,
    parameter int ACCESS_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic [63:0] valE,
    input  logic [63:0] valA,
    input  logic [63:0] valP,
    output logic        out_valid,
    output logic [63:0] valM,
    output logic [2:0]  stat
);

    localparam int          AW         = $clog2(MEM_BYTES);
    localparam int          CW         = (ACCESS_LAT > 1) ? $clog2(ACCESS_LAT) : 1;
    // Highest legal start address; compared against the full 64-bit address so nothing wraps.
    localparam logic [63:0] ADDR_LIMIT = 64'(MEM_BYTES - 8);

    mem_state_e    state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          done;

    logic [63:0]   acc_addr;
    logic [63:0]   acc_wdata;
    logic          acc_wr;
    logic          acc_rd;
    logic          dmem_err;
    logic [2:0]    acc_stat;

    logic [AW-1:0] lat_addr;
    logic [63:0]   lat_wdata;
    logic          lat_wr;
    logic          lat_rd;
    logic [2:0]    lat_stat;

    logic [63:0]   rd_dat;
    logic [63:0]   valm_rsp;
    logic [63:0]   valm_q;
    logic [2:0]    stat_q;
    logic          mem_we;

    // Decode the access type, address and write data from the incoming request.
    always_comb begin
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        acc_addr  = valE;
        acc_wdata = valA;
        case (icode)
            IRMMOVQ, IPUSHQ: acc_wr = 1'b1;
            ICALL: begin
                acc_wr    = 1'b1;
                acc_wdata = valP;
            end
            IMRMOVQ: acc_rd = 1'b1;
            IRET, IPOPQ: begin
                acc_rd   = 1'b1;
                acc_addr = valA;
            end
            default: ;
        endcase
`ifdef MEM_ALIGN_CHECK_EN
        dmem_err = (acc_wr | acc_rd) & ((acc_addr > ADDR_LIMIT) | (acc_addr[2:0] != 3'd0));
`else
        dmem_err = (acc_wr | acc_rd) & (acc_addr > ADDR_LIMIT);
`endif
        acc_stat = resolve_stat(imem_error | dmem_err, instr_valid, icode);
    end

    assign in_ready = rst_n & (state == ST_IDLE);
    assign accept   = in_valid & in_ready;

    // Next-state logic; done marks the single response cycle at the end of BUSY.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid) state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = (lat_stat == SAOK) ? ST_IDLE : ST_HALTED;
                end
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State, latency counter and held response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            valm_q <= '0;
            stat_q <= SAOK;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= CW'(ACCESS_LAT - 1);
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (out_valid) begin
                valm_q <= valm_rsp;
                stat_q <= lat_stat;
            end
        end
    end

    // Request capture; only meaningful while BUSY, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_addr  <= acc_addr[AW-1:0];
            lat_wdata <= acc_wdata;
            lat_wr    <= acc_wr;
            lat_rd    <= acc_rd;
            lat_stat  <= acc_stat;
        end
    end

    // Reset during the response cycle suppresses both the strobe and the write.
    assign out_valid = done & rst_n;
    assign mem_we    = out_valid & lat_wr & (lat_stat == SAOK);
    assign valm_rsp  = (lat_rd && lat_stat == SAOK) ? rd_dat : 64'd0;
    assign valM      = out_valid ? valm_rsp : valm_q;
    assign stat      = out_valid ? lat_stat : stat_q;

    dmem_array #(
        .MEM_BYTES (MEM_BYTES),
        .AW        (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (lat_addr),
        .wdata (lat_wdata),
        .raddr (lat_addr),
        .rdata (rd_dat)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized traffic against a byte-array model.
// Latency: response expected ACCESS_LAT cycles after each accept.
// Backpressure: driver waits (bounded) for in_ready; monitor flags any unexpected strobe.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;
    localparam int LAT       = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic [63:0] valE;
    logic [63:0] valA;
    logic [63:0] valP;
    logic        out_valid;
    logic [63:0] valM;
    logic [2:0]  stat;

    memory_stage #(
        .MEM_BYTES  (MEM_BYTES),
        .ACCESS_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .valE        (valE),
        .valA        (valA),
        .valP        (valP),
        .out_valid   (out_valid),
        .valM        (valM),
        .stat        (stat)
    );

    typedef struct {
        logic [63:0] valm;
        logic [2:0]  st;
        int          acc_edge;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mm [MEM_BYTES];
    int         n_cmp = 0;
    int         n_err = 0;
    int         edge_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic fail(input string nm, input string why);
        n_cmp++;
        n_err++;
        $display("FAIL %s %s", nm, why);
    endtask

    // Reference model: Y86 memory semantics over a plain byte array.
    task automatic model(input logic [3:0] ic, input logic iv, input logic ime,
                         input logic [63:0] vE, input logic [63:0] vA, input logic [63:0] vP,
                         output logic [63:0] em, output logic [2:0] es);
        bit              wr, rd, err;
        logic [63:0]     a, d;
        longint unsigned lim;
        lim = MEM_BYTES - 8;
        wr  = (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
        rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        a   = (ic == 4'h9 || ic == 4'hB) ? vA : vE;
        d   = (ic == 4'h8) ? vP : vA;
        err = (wr || rd) && (a > lim);
`ifdef MEM_ALIGN_CHECK_EN
        if ((wr || rd) && (a % 8 != 0)) err = 1'b1;
`endif
        if (ime || err)   es = 3'd3;
        else if (!iv)     es = 3'd4;
        else if (ic == 0) es = 3'd2;
        else              es = 3'd1;
        em = 64'd0;
        if (es == 3'd1 && wr) for (int i = 0; i < 8; i++) mm[int'(a) + i] = d[8*i +: 8];
        if (es == 3'd1 && rd) for (int i = 0; i < 8; i++) em[8*i +: 8] = mm[int'(a) + i];
    endtask

    // Monitor: every strobe must match the oldest expectation, including its latency.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                fail("unexpected_resp", $sformatf("actual out_valid=1 valM=%h stat=%0d required no response", valM, stat));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_valM", valM, e.valm);
                chk("resp_stat", 64'(stat), 64'(e.st));
                chk("resp_latency", 64'(edge_cnt - e.acc_edge), 64'(LAT - 1));
            end
        end
    end

    task automatic send(input logic [3:0] ic, input logic iv, input logic ime,
                        input logic [63:0] vE, input logic [63:0] vA, input logic [63:0] vP,
                        input bit track, output logic [2:0] st);
        int   t;
        exp_t e;
        st = 3'd1;
        t  = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            fail("ready_timeout", "actual in_ready=0 required 1 within 100 cycles");
            return;
        end
        icode       = ic;
        instr_valid = iv;
        imem_error  = ime;
        valE        = vE;
        valA        = vA;
        valP        = vP;
        in_valid    = 1'b1;
        if (track) begin
            model(ic, iv, ime, vE, vA, vP, e.valm, e.st);
            e.acc_edge = edge_cnt + 1;
            st = e.st;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            fail("resp_timeout", $sformatf("actual %0d responses missing required 0", exp_q.size()));
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("rst_in_ready_async", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_stat", 64'(stat), 64'd1);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // After a non-AOK result the block must refuse everything until reset.
    task automatic halt_check(input logic [2:0] st);
        drain();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            icode       = 4'h5;
            instr_valid = 1'b1;
            imem_error  = 1'b0;
            valE        = 64'h0;
            in_valid    = 1'b1;
            chk("halt_in_ready", 64'(in_ready), 64'd0);
            chk("halt_stat", 64'(stat), 64'(st));
        end
        @(negedge clk);
        in_valid = 1'b0;
        do_reset();
    endtask

    task automatic req(input logic [3:0] ic, input logic iv, input logic ime,
                       input logic [63:0] vE, input logic [63:0] vA, input logic [63:0] vP);
        logic [2:0] st;
        send(ic, iv, ime, vE, vA, vP, 1'b1, st);
        if (st != 3'd1) halt_check(st);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [2:0]  st;
        logic [3:0]  ic;
        logic [63:0] a;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        icode       = 4'h1;
        instr_valid = 1'b1;
        imem_error  = 1'b0;
        valE        = '0;
        valA        = '0;
        valP        = '0;
        do_reset();

        // Give every byte a known value so any later read is predictable.
        for (int w = 0; w < MEM_BYTES / 8; w++) req(4'h4, 1, 0, 64'(w * 8), rnd64(), 64'h0);

        // Store then load back through mrmovq.
        req(4'h4, 1, 0, 64'h100, 64'h1122334455667788, 64'h0);
        req(4'h5, 1, 0, 64'h100, 64'h0, 64'h0);
        // Stack push/pop and call/ret.
        req(4'hA, 1, 0, 64'h1F8, 64'd42, 64'h0);
        req(4'hB, 1, 0, 64'h0, 64'h1F8, 64'h0);
        req(4'h8, 1, 0, 64'h1F0, 64'h0, 64'h40);
        req(4'h9, 1, 0, 64'h0, 64'h1F0, 64'h0);
        // Non-memory op returns zero.
        req(4'h6, 1, 0, 64'h100, 64'h100, 64'h0);
        // Out-of-range reads, including one near 2^64.
        req(4'h5, 1, 0, 64'(MEM_BYTES - 4), 64'h0, 64'h0);
        req(4'h5, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0);
        // Last legal word.
        req(4'h5, 1, 0, 64'(MEM_BYTES - 8), 64'h0, 64'h0);
        // Halt, and ADR outranking INS; failed store must leave memory intact.
        req(4'h0, 1, 0, 64'h100, 64'hDEAD, 64'h0);
        req(4'h4, 0, 1, 64'h200, 64'hBAD0BAD0BAD0BAD0, 64'h0);
        req(4'h4, 0, 0, 64'h208, 64'hBAD1BAD1BAD1BAD1, 64'h0);
        req(4'h5, 1, 0, 64'h200, 64'h0, 64'h0);
        req(4'h5, 1, 0, 64'h208, 64'h0, 64'h0);
        // Reset one cycle after accepting a store: the store must vanish.
        send(4'h4, 1, 0, 64'h80, 64'hA5A5_A5A5_5A5A_5A5A, 64'h0, 1'b0, st);
        do_reset();
        req(4'h5, 1, 0, 64'h80, 64'h0, 64'h0);
        // Unaligned store and readback.
        req(4'h4, 1, 0, 64'h103, 64'h0123456789ABCDEF, 64'h0);
        req(4'h5, 1, 0, 64'h103, 64'h0, 64'h0);
        req(4'h5, 1, 0, 64'h100, 64'h0, 64'h0);

        // Randomized traffic, mostly legal with occasional faults.
        for (int n = 0; n < 300; n++) begin
            ic = 4'($urandom_range(0, 11));
            if (ic == 4'h0 && ($urandom % 4) != 0) ic = 4'h1;
            a = 64'($urandom_range(0, MEM_BYTES - 8));
            if (($urandom % 4) != 0) a = a & ~64'h7;
            if (($urandom % 25) == 0)
                a = ($urandom % 2) ? 64'(MEM_BYTES - 7 + $urandom_range(0, 6))
                                   : (64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7)));
            req(ic, ($urandom % 30) != 0, ($urandom % 30) == 0, a,
                (ic == 4'h9 || ic == 4'hB) ? a : rnd64(), rnd64());
        end

        drain();
        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #800000;
        fail("watchdog", "actual bench still running required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
